// File: rtl/master_apb_pkg.sv
// rtl/master_apb_pkg.sv - shared FSM state and response status codes for the APB master
//
// Purpose : common types for master_apb_param.
// Contents: state_t   - transfer FSM states (IDLE, SETUP, ACCESS, RESP)
//           ST_OK      - response status, transfer completed without error
//           ST_SLVERR  - response status, slave signalled PSLVERR
//           ST_TIMEOUT - response status, slave never raised PREADY in time

package master_apb_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SETUP  = 2'b01,
    S_ACCESS = 2'b10,
    S_RESP   = 2'b11
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_SLVERR  = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

endpackage

// File: rtl/master_apb_param.sv
// rtl/master_apb_param.sv - single-outstanding APB4 master with command/response handshakes
//
// Purpose : turns one command (valid/ready) into one APB transfer and returns one
//           response (valid/ready) carrying read data and a 2-bit status.
// Params  : AW (address width), DW (data width 8/16/32), TO_CYC (ACCESS cycle limit).
// Macro   : APB_MASTER_PARAM_TIMEOUT_EN - when defined, a transfer whose slave holds
//           PREADY low for TO_CYC ACCESS cycles is ended with status ST_TIMEOUT.
//           When undefined the master waits for PREADY indefinitely.
// Ports   : i_pclk, i_presetn              clock, async active-low reset
//           i_cmd_*, o_cmd_ready           command channel
//           o_rsp_*, i_rsp_ready           response channel (rdata, status)
//           o_irq                          one-cycle pulse per non-OK response
//           o_p*, i_prdata/pready/pslverr  APB master interface

module master_apb_param
  import master_apb_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int TO_CYC = 255
) (
  input  logic            i_pclk,
  input  logic            i_presetn,
  input  logic            i_cmd_valid,
  output logic            o_cmd_ready,
  input  logic            i_cmd_write,
  input  logic [AW-1:0]   i_cmd_addr,
  input  logic [DW-1:0]   i_cmd_wdata,
  input  logic [DW/8-1:0] i_cmd_strb,
  input  logic [2:0]      i_cmd_prot,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [DW-1:0]   o_rsp_rdata,
  output logic [1:0]      o_rsp_status,
  output logic            o_irq,
  output logic            o_psel,
  output logic            o_penable,
  output logic            o_pwrite,
  output logic [AW-1:0]   o_paddr,
  output logic [DW-1:0]   o_pwdata,
  output logic [2:0]      o_pprot,
  output logic [DW/8-1:0] o_pstrb,
  input  logic [DW-1:0]   i_prdata,
  input  logic            i_pready,
  input  logic            i_pslverr
);

  if (TO_CYC < 1 || TO_CYC > 65535) begin : g_bad_to_cyc
    $error("master_apb_param: TO_CYC must be within 1..65535");
  end

  state_t     state, state_n;
  logic       access_done;
  logic [1:0] done_status;

`ifdef APB_MASTER_PARAM_TIMEOUT_EN
  // Counts completed ACCESS cycles; value TO_LAST marks the final allowed cycle.
  localparam logic [15:0] TO_LAST = 16'(TO_CYC - 1);
  logic [15:0] to_cnt;
`endif

  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    access_done = 1'b0;
    done_status = ST_OK;
    case (state)
      S_IDLE: begin
        if (i_cmd_valid) state_n = S_SETUP;
      end
      S_SETUP: begin
        state_n = S_ACCESS;
      end
      S_ACCESS: begin
        // PSLVERR is only sampled with PREADY, so a slave error in the last
        // allowed cycle wins over the timeout.
        if (i_pready) begin
          access_done = 1'b1;
          done_status = i_pslverr ? ST_SLVERR : ST_OK;
        end
`ifdef APB_MASTER_PARAM_TIMEOUT_EN
        else if (to_cnt == TO_LAST) begin
          access_done = 1'b1;
          done_status = ST_TIMEOUT;
        end
`endif
        if (access_done) state_n = S_RESP;
      end
      S_RESP: begin
        if (i_rsp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Reset gates ready so every output reads 0 while reset is held.
  assign o_cmd_ready = (state == S_IDLE) && i_presetn;
  assign o_psel      = (state == S_SETUP) || (state == S_ACCESS);
  assign o_penable   = (state == S_ACCESS);
  assign o_rsp_valid = (state == S_RESP);

  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      o_pwrite     <= 1'b0;
      o_paddr      <= '0;
      o_pwdata     <= '0;
      o_pprot      <= '0;
      o_pstrb      <= '0;
      o_rsp_rdata  <= '0;
      o_rsp_status <= ST_OK;
      o_irq        <= 1'b0;
    end else begin
      o_irq <= 1'b0;
      if (state == S_IDLE && i_cmd_valid) begin
        o_pwrite <= i_cmd_write;
        o_paddr  <= i_cmd_addr;
        o_pprot  <= i_cmd_prot;
        o_pstrb  <= i_cmd_write ? i_cmd_strb : '0;
        // Write data bus keeps the last written value across reads.
        if (i_cmd_write) o_pwdata <= i_cmd_wdata;
      end
      if (access_done) begin
        o_rsp_rdata  <= (!o_pwrite && done_status == ST_OK) ? i_prdata : '0;
        o_rsp_status <= done_status;
        o_irq        <= (done_status != ST_OK);
      end
    end
  end

`ifdef APB_MASTER_PARAM_TIMEOUT_EN
  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      to_cnt <= '0;
    end else if (state == S_SETUP) begin
      to_cnt <= '0;
    end else if (state == S_ACCESS) begin
      to_cnt <= to_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/master_apb_param.md
MASTER_APB_PARAM -- requirements
Module: master_apb_param
Interface
REQ-001 SHALL have parameter AW, default 32, APB address width (8..32).
REQ-002 SHALL have parameter DW, default 32, APB data width (8, 16, 32); strobe width DW/8.
REQ-003 SHALL have parameter TO_CYC, default 255, maximum ACCESS cycles before timeout (1..65535).
REQ-004 SHALL have port i_pclk  in  1  clock; all state on rising edge.
REQ-005 SHALL have port i_presetn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_cmd_valid  in  1  command request.
REQ-007 SHALL have port o_cmd_ready  out  1  command accepted when both high.
REQ-008 SHALL have port i_cmd_write  in  1  1 = write, 0 = read.
REQ-009 SHALL have port i_cmd_addr  in  AW  transfer address.
REQ-010 SHALL have port i_cmd_wdata  in  DW  write data.
REQ-011 SHALL have port i_cmd_strb  in  DW/8  write byte strobes.
REQ-012 SHALL have port i_cmd_prot  in  3  protection attributes.
REQ-013 SHALL have port o_rsp_valid  out  1  response available.
REQ-014 SHALL have port i_rsp_ready  in  1  response consumed when both high.
REQ-015 SHALL have port o_rsp_rdata  out  DW  read data; 0 for writes and errors.
REQ-016 SHALL have port o_rsp_status  out  2  00 OK, 01 PSLVERR, 10 timeout.
REQ-017 SHALL have port o_irq  out  1  one-cycle pulse per non-OK response.
REQ-018 SHALL have ports o_psel, o_penable, o_pwrite (1), o_paddr (AW), o_pwdata (DW), o_pprot (3), o_pstrb (DW/8)  out  APB request.
REQ-019 SHALL have ports i_prdata (DW), i_pready (1), i_pslverr (1)  in  APB completion.
Function
REQ-020 SHALL implement FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE; o_cmd_ready = 1 only in IDLE.
REQ-021 SHALL, on cmd handshake in IDLE, register addr/wdata/strb/prot/write and enter SETUP next cycle with o_psel=1, o_penable=0.
REQ-022 SHALL move SETUP -> ACCESS unconditionally after one cycle, o_psel=1, o_penable=1, APB outputs held stable.
REQ-023 SHALL stay in ACCESS while i_pready=0; on i_pready=1 capture i_prdata (reads only) and i_pslverr, then enter RESP, dropping o_psel/o_penable.
REQ-024 SHALL assert o_rsp_valid in RESP, hold rdata/status stable until i_rsp_ready=1, then return to IDLE; minimum command-to-response latency 3 cycles.
REQ-025 SHALL drive o_pstrb = 0 on reads (APB4 rule); o_pwdata holds last write value when idle.
REQ-026 SHALL pulse o_irq for exactly one cycle on RESP entry when status != 00.
REQ-027 SHALL give PSLVERR priority over timeout when both occur in the same cycle.
Reset
REQ-028 SHALL on i_presetn=0 immediately force IDLE, all outputs 0 (o_cmd_ready=1 after release), regardless of in-flight transfer; aborted transfer generates no response.
Configuration
REQ-029 SHALL, with APB_MASTER_PARAM_TIMEOUT_EN defined, count ACCESS cycles and, when count reaches TO_CYC with i_pready=0, end the transfer, status 10, rdata 0.
REQ-030 SHALL, without APB_MASTER_PARAM_TIMEOUT_EN, omit the counter entirely, wait indefinitely for i_pready, and never report status 10.
Structure
REQ-031 SHALL place FSM state enum and status code constants (ST_OK, ST_SLVERR, ST_TIMEOUT) in shared package master_apb_pkg.
REQ-032 SHALL be a single module; no sub-module.
Verification
REQ-033 Write addr 0x10, data 0xA5A5A5A5, strb 0xF, i_pready=1 -> SETUP then ACCESS one cycle each, rsp status 00 after 3 cycles, o_irq=0.
REQ-034 Read addr 0x20, i_pready low 4 cycles, prdata 0x12345678 -> ACCESS lasts 5 cycles, rdata 0x12345678, o_pstrb=0 throughout.
REQ-035 Write with i_pslverr=1 at completion -> status 01, rdata 0, o_irq one-cycle pulse.
REQ-036 TIMEOUT_EN, TO_CYC=4, i_pready held 0 -> transfer ends after 4 ACCESS cycles, status 10, o_irq pulse; without macro stays in ACCESS.
REQ-037 i_rsp_ready low 3 cycles in RESP -> o_rsp_valid/rdata/status stable, o_cmd_ready=0, new command not accepted.
REQ-038 i_presetn asserted mid-ACCESS -> o_psel/o_penable 0 same cycle, no response after release, next command completes normally.
